// File: rtl/tank_pkg.sv
// tank_pkg: shared heading encodings, AI state type and index-to-heading helper.
package tank_pkg;
    localparam logic [3:0] DIR_DOWN  = 4'b0001;
    localparam logic [3:0] DIR_UP    = 4'b0010;
    localparam logic [3:0] DIR_RIGHT = 4'b0100;
    localparam logic [3:0] DIR_LEFT  = 4'b1000;

    typedef enum logic [1:0] {IDLE = 2'd0, TURN = 2'd1, MOVE = 2'd2, PAUSE = 2'd3} ai_state_t;

    function automatic logic [3:0] dir_from_idx(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction
endpackage

// File: rtl/tank_ai_ctrl_if.sv
// tank_ai_ctrl_if: control/status bundle between an enemy-tank AI and its tank block.
interface tank_ai_ctrl_if;
    logic       frame_tick_i;
    logic       enable_i;
    logic       tank_die_i;
    logic       bullet_busy_i;
    logic       collide_top_i;
    logic       collide_bottom_i;
    logic       collide_left_i;
    logic       collide_right_i;
    logic [3:0] tank_move_o;
    logic       tank_shoot_o;
    logic [1:0] ai_state_o;

    modport master (
        input  frame_tick_i, enable_i, tank_die_i, bullet_busy_i,
               collide_top_i, collide_bottom_i, collide_left_i, collide_right_i,
        output tank_move_o, tank_shoot_o, ai_state_o
    );
    modport slave (
        output frame_tick_i, enable_i, tank_die_i, bullet_busy_i,
               collide_top_i, collide_bottom_i, collide_left_i, collide_right_i,
        input  tank_move_o, tank_shoot_o, ai_state_o
    );
endinterface

// File: rtl/lfsr16.sv
// lfsr16: free-running 16-bit Galois LFSR, x^16+x^14+x^13+x^11; a zero seed becomes 1.
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk_i,
    input  logic        reset_i,
    output logic [15:0] lfsr
);
    localparam logic [15:0] INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;

    always_ff @(posedge clk_i)
        if (reset_i) lfsr <= INIT;
        else lfsr <= (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 16'h0000);
endmodule

// File: rtl/tank_ai_ctrl.sv
// tank_ai_ctrl: random-walk/turn/pause FSM with periodic fire for one enemy tank.
// Define TANK_AI_AIM_EN to add position ports for target-biased turns and early fire.
module tank_ai_ctrl
    import tank_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED    = 16'hACE1,
    parameter logic [3:0]  DIR_INIT     = 4'b0001,
    parameter logic [7:0]  MIN_RUN      = 8'd32,
    parameter logic [7:0]  RUN_MASK     = 8'h3F,
    parameter logic [7:0]  PAUSE_FRAMES = 8'd30,
    parameter logic [7:0]  SHOOT_PERIOD = 8'd90
) (
    input  logic          clk_i,
    input  logic          reset_i,
`ifdef TANK_AI_AIM_EN
    input  logic [9:0]    self_x_i,
    input  logic [9:0]    self_y_i,
    input  logic [9:0]    target_x_i,
    input  logic [9:0]    target_y_i,
`endif
    tank_ai_ctrl_if.master bus
);
    localparam logic [7:0] SHOOT_LAST = SHOOT_PERIOD - 8'd1;

    ai_state_t   state, state_n;
    logic [3:0]  dir, dir_n, move, move_n, blocked;
    logic [7:0]  run_cnt, run_n, pause_cnt, pause_n, shoot_cnt, shoot_cnt_n, run_val;
    logic        shoot, shoot_n, kill, tick, hit, found, fire, early;
    logic [1:0]  start, pick;
    logic [8:0]  run_sum;
    logic [15:0] lfsr;
    logic [5:0]  unused_lfsr;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (.clk_i(clk_i), .reset_i(reset_i), .lfsr(lfsr));

    assign unused_lfsr = lfsr[15:10];
    assign kill    = !bus.enable_i || bus.tank_die_i;
    assign tick    = bus.frame_tick_i;
    // Bit i of blocked lines up with bit i of the one-hot heading.
    assign blocked = {bus.collide_left_i, bus.collide_right_i, bus.collide_top_i, bus.collide_bottom_i};
    assign hit     = |(dir & blocked);
    assign run_sum = {1'b0, MIN_RUN} + {1'b0, lfsr[9:2] & RUN_MASK};
    assign run_val = run_sum[8] ? 8'hFF : run_sum[7:0];

`ifdef TANK_AI_AIM_EN
    logic [10:0] dx, dy, adx, ady;
    logic [1:0]  aim_idx;
    logic        near;
    assign dx      = {1'b0, target_x_i} - {1'b0, self_x_i};
    assign dy      = {1'b0, target_y_i} - {1'b0, self_y_i};
    assign adx     = dx[10] ? -dx : dx;
    assign ady     = dy[10] ? -dy : dy;
    assign aim_idx = (ady >= adx) ? ((!dy[10] && |dy) ? 2'd0 : 2'd1) : (dx[10] ? 2'd3 : 2'd2);
    assign near    = (dir[0] || dir[1]) ? (adx < 11'd8) : (ady < 11'd8);
    assign start   = lfsr[2] ? aim_idx : lfsr[1:0];
    assign early   = state == MOVE && near && shoot_cnt >= (SHOOT_PERIOD >> 1);
`else
    assign start = lfsr[1:0];
    assign early = 1'b0;
`endif

    assign fire = (state == MOVE || state == PAUSE) && tick && !bus.bullet_busy_i &&
                  (shoot_cnt == SHOOT_LAST || early);

    // Walk the four headings from start; the lowest rotation that is free wins.
    always_comb begin
        found = 1'b0;
        pick  = start;
        for (int k = 3; k >= 0; k--)
            if (!blocked[start + 2'(k)]) begin
                found = 1'b1;
                pick  = start + 2'(k);
            end
    end

    always_comb begin
        state_n     = state;
        dir_n       = dir;
        run_n       = run_cnt;
        pause_n     = pause_cnt;
        shoot_cnt_n = shoot_cnt;
        shoot_n     = tick ? 1'b0 : shoot;
        if (fire) begin
            shoot_n     = 1'b1;
            shoot_cnt_n = 8'd0;
        end else if ((state == MOVE || state == PAUSE) && tick && shoot_cnt != SHOOT_LAST)
            shoot_cnt_n = shoot_cnt + 8'd1;
        case (state)
            IDLE: begin
                shoot_cnt_n = 8'd0;
                shoot_n     = 1'b0;
                state_n     = TURN;
            end
            TURN: begin
                state_n = found ? MOVE : PAUSE;
                dir_n   = found ? dir_from_idx(pick) : dir;
                run_n   = found ? run_val : run_cnt;
                pause_n = found ? pause_cnt : PAUSE_FRAMES;
            end
            MOVE: begin
                run_n   = (!hit && tick) ? run_cnt - 8'd1 : run_cnt;
                state_n = (hit || (tick && run_cnt <= 8'd1)) ? TURN : MOVE;
            end
            PAUSE: begin
                pause_n = tick ? pause_cnt - 8'd1 : pause_cnt;
                state_n = (tick && pause_cnt <= 8'd1) ? TURN : PAUSE;
            end
            default: state_n = IDLE;
        endcase
        if (kill) begin
            state_n = IDLE;
            shoot_n = 1'b0;
        end
        move_n = (state_n == MOVE) ? dir_n : 4'b0000;
    end

    always_ff @(posedge clk_i)
        if (reset_i) begin
            state     <= IDLE;
            dir       <= DIR_INIT;
            move      <= 4'b0000;
            run_cnt   <= 8'd0;
            pause_cnt <= 8'd0;
            shoot_cnt <= 8'd0;
            shoot     <= 1'b0;
        end else begin
            state     <= state_n;
            dir       <= dir_n;
            move      <= move_n;
            run_cnt   <= run_n;
            pause_cnt <= pause_n;
            shoot_cnt <= shoot_cnt_n;
            shoot     <= shoot_n;
        end

    assign bus.tank_move_o  = move;
    assign bus.tank_shoot_o = shoot;
    assign bus.ai_state_o   = state;
endmodule

// File: tb/tb_tank_ai_ctrl.sv
// tb_tank_ai_ctrl: directed bench for tank_ai_ctrl built with SHOOT_PERIOD=4.
// From seed ACE1 the first TURN sees LFSR=E270: heading down, run of 32+28=60 ticks.
module tb_tank_ai_ctrl;
    logic clk_i = 1'b0;
    logic reset_i;
    int   checks = 0;
    int   errors = 0;

    tank_ai_ctrl_if bus();

    always #5 clk_i = ~clk_i;

    tank_ai_ctrl #(.SHOOT_PERIOD(8'd4)) dut (
        .clk_i(clk_i),
        .reset_i(reset_i),
`ifdef TANK_AI_AIM_EN
        .self_x_i(10'd0),
        .self_y_i(10'd0),
        .target_x_i(10'd0),
        .target_y_i(10'd0),
`endif
        .bus(bus)
    );

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic tick();
        bus.frame_tick_i = 1'b1;
        step(1);
        bus.frame_tick_i = 1'b0;
    endtask

    task automatic restart();
        reset_i = 1'b1;
        step(2);
        reset_i = 1'b0;
    endtask

    task automatic set_walls(input logic [3:0] w);
        {bus.collide_left_i, bus.collide_right_i, bus.collide_top_i, bus.collide_bottom_i} = w;
    endtask

    initial begin
        reset_i           = 1'b1;
        bus.frame_tick_i  = 1'b0;
        bus.enable_i      = 1'b0;
        bus.tank_die_i    = 1'b0;
        bus.bullet_busy_i = 1'b0;
        set_walls(4'b0000);
        step(3);
        check("reset_state", bus.ai_state_o, 4'd0);
        check("reset_move", bus.tank_move_o, 4'd0);
        check("reset_shoot", bus.tank_shoot_o, 4'd0);

        // Run length and periodic fire
        bus.enable_i = 1'b1;
        reset_i = 1'b0;
        step(1);
        check("first_turn", bus.ai_state_o, 4'd1);
        check("turn_move", bus.tank_move_o, 4'd0);
        step(1);
        check("first_move", bus.ai_state_o, 4'd2);
        check("first_dir", bus.tank_move_o, 4'b0001);
        for (int k = 1; k <= 59; k++) begin
            tick();
            check("run_state", bus.ai_state_o, 4'd2);
            check("run_dir", bus.tank_move_o, 4'b0001);
            check("periodic_shoot", bus.tank_shoot_o, {3'b0, (k % 4) == 0});
            step(2);
        end
        tick();
        check("run_end_turn", bus.ai_state_o, 4'd1);
        check("run_end_shoot", bus.tank_shoot_o, 4'd1);
        step(1);
        check("second_move", bus.ai_state_o, 4'd2);
        check("second_onehot", {3'b0, $onehot(bus.tank_move_o)}, 4'd1);

        // Wall in heading, then kill while firing
        restart();
        step(2);
        check("b_dir", bus.tank_move_o, 4'b0001);
        set_walls(4'b0001);
        step(1);
        check("blocked_turn", bus.ai_state_o, 4'd1);
        check("blocked_turn_move", bus.tank_move_o, 4'd0);
        step(1);
        check("blocked_move", bus.ai_state_o, 4'd2);
        check("new_dir", {3'b0, bus.tank_move_o != 4'b0001 && $onehot(bus.tank_move_o)}, 4'd1);
        for (int k = 1; k <= 4; k++) begin
            tick();
            step(1);
        end
        step(-1 + 1);
        check("pre_die_state", bus.ai_state_o, 4'd2);
        check("pre_die_shoot", bus.tank_shoot_o, 4'd1);
        bus.tank_die_i = 1'b1;
        step(1);
        check("die_state", bus.ai_state_o, 4'd0);
        check("die_move", bus.tank_move_o, 4'd0);
        check("die_shoot", bus.tank_shoot_o, 4'd0);
        bus.tank_die_i = 1'b0;
        set_walls(4'b0000);
        step(1);
        check("revive_turn", bus.ai_state_o, 4'd1);
        step(1);
        check("revive_move", bus.ai_state_o, 4'd2);

        // Boxed in: pause, fire held off by busy bullet
        set_walls(4'b1111);
        restart();
        step(2);
        check("pause_state", bus.ai_state_o, 4'd3);
        check("pause_move", bus.tank_move_o, 4'd0);
        bus.bullet_busy_i = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check("busy_no_shoot", bus.tank_shoot_o, 4'd0);
            step(1);
        end
        bus.bullet_busy_i = 1'b0;
        tick();
        check("busy_release_shoot", bus.tank_shoot_o, 4'd1);
        for (int k = 12; k <= 29; k++) begin
            step(1);
            tick();
            check("pause_hold", bus.ai_state_o, 4'd3);
            check("pause_shoot", bus.tank_shoot_o, {3'b0, ((k - 11) % 4) == 0});
        end
        step(1);
        tick();
        check("pause_end_turn", bus.ai_state_o, 4'd1);
        set_walls(4'b0000);
        step(1);
        check("after_pause_move", bus.ai_state_o, 4'd2);
        check("after_pause_onehot", {3'b0, $onehot(bus.tank_move_o)}, 4'd1);
        bus.enable_i = 1'b0;
        step(1);
        check("disable_idle", bus.ai_state_o, 4'd0);
        check("disable_move", bus.tank_move_o, 4'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
